pc_stack_unit: RTL
==================

# pc_stack_unit

Parametrised program-counter unit that generalises the fetch-stage PC: sequential increment, PC-relative and absolute conditional branches, unconditional jumps, and subroutine call/return through an internal return-address stack. It drives the instruction-memory address every cycle. It accepts a pipeline stall. Stack overflow or underflow latches a sticky fault that freezes the PC until reset.

## Interface
- D, 8, PC/address width in bits
- OFF_W, 6, relative-branch offset width, two's complement
- STACK_DEPTH, 4, number of return-address entries (≥1)
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clock clk
- stall  input  1  hold all state this cycle (lower priority than reset)
- op  input  3  000 NEXT, 001 BR_REL, 010 BR_ABS, 011 JMP, 100 CALL, 101 RET, 110/111 treated as NEXT
- cond  input  1  branch condition; used only by BR_REL/BR_ABS
- target  input  D  absolute destination for BR_ABS/JMP/CALL
- offset  input  OFF_W  signed displacement for BR_REL
- prog_ctr  output  D  current PC (registered)
- depth  output  $clog2(STACK_DEPTH+1)  valid stack entries
- stack_empty  output  1  depth==0
- stack_full  output  1  depth==STACK_DEPTH
- ret_top  output  D  top-of-stack entry; 0 when empty
- fault  output  1  sticky overflow/underflow flag

## Operation
- Two states: RUN, FAULT. Reset → RUN.
- Reset values: prog_ctr=RESET_PC, depth=0, stack entries=0, fault=0, ret_top=0, stack_empty=1, stack_full=0.
- Priority per edge: reset > FAULT hold > stall > op.
- RUN, no stall, by op. All PC arithmetic is modulo 2^D with silent wrap.
  - NEXT: prog_ctr+1.
  - BR_REL: if cond, prog_ctr + sext(offset); else prog_ctr+1. The offset is relative to the branch's own PC.
  - BR_ABS: if cond, target; else prog_ctr+1.
  - JMP: target, regardless of cond.
  - CALL:
    - If not full: push prog_ctr+1 (wrapped), depth+1, prog_ctr=target.
    - If full: no push, prog_ctr unchanged, fault=1, go to FAULT.
  - RET:
    - If not empty: prog_ctr=ret_top, pop, depth−1.
    - If empty: prog_ctr unchanged, fault=1, go to FAULT.
- FAULT: prog_ctr, stack and depth frozen, and every op and stall is ignored. Only reset exits FAULT.
- stall=1 in RUN: prog_ctr, stack, depth and fault all hold, and op is ignored.
- The stack is LIFO. Entries above depth are don't-care and must never reach ret_top.
- Flags stack_empty, stack_full and ret_top are combinational from registered depth/stack. They reflect the post-edge state.

## Timing
- Single-cycle: an op presented in cycle N takes effect at posedge ending N. New prog_ctr is visible in cycle N+1.
- Back-to-back CALL/RET every cycle is supported with no bubbles. A RET immediately after a CALL returns to the CALL's PC+1.
- CALL at prog_ctr=2^D−1 pushes 0. BR_REL with prog_ctr=0 and offset=−1 yields 2^D−1.
- Reset asserted mid-sequence (stack non-empty or FAULT) restores all reset values on that edge, regardless of stall/op.
- No combinational path from inputs to any output.

## Test plan
- Reset then 5 cycles NEXT → prog_ctr 0,1,2,3,4,5. At prog_ctr=255 NEXT → 0.
- At prog_ctr=0x10:
  - BR_REL, cond=1, offset=6'b111100 (−4) → 0x0C.
  - Same with cond=0 → 0x11.
  - BR_ABS, cond=1, target=0x80 → 0x80.
  - JMP, cond=0, target=0x40 → 0x40.
- Nested calls from 0x20:
  - CALL 0x50 → prog_ctr 0x50, depth 1, ret_top 0x21.
  - CALL 0x60 → 0x60, depth 2, ret_top 0x51.
  - RET → 0x51, depth 1. RET → 0x21, depth 0, stack_empty=1.
- Four CALLs fill the stack (stack_full=1). A fifth CALL → fault=1, prog_ctr unchanged, depth 4. Any further op has no effect. Reset → prog_ctr 0, depth 0, fault 0.
- RET at depth 0 → fault=1, prog_ctr held. Separately, stall=1 with op=CALL for 3 cycles → no change to prog_ctr or depth. Deasserting stall → the call executes on the next edge.
- Reset asserted concurrently with stall=1 and op=CALL at depth 2 → all reset values next cycle.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with branch/jump decode and a return-address stack for CALL/RET.
// Latency: one cycle; an op presented in cycle N sets prog_ctr and stack state seen in cycle N+1.
// Backpressure: stall holds all state; stack overflow/underflow freezes the unit until reset.
module pc_stack_unit #(
    parameter int D           = 8,
    parameter int OFF_W       = 6,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic                               cond,
    input  logic [D-1:0]                       target,
    input  logic [OFF_W-1:0]                   offset,
    output logic [D-1:0]                       prog_ctr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic [D-1:0]                       ret_top,
    output logic                               fault
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    // Index width for the entry array; at least one bit even for a single-entry stack.
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_NEXT   = 3'b000;
    localparam logic [2:0] OP_BR_REL = 3'b001;
    localparam logic [2:0] OP_BR_ABS = 3'b010;
    localparam logic [2:0] OP_JMP    = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [D-1:0]   pc_q;
    logic [D-1:0]   pc_d;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   off_ext;
    logic [D-1:0]   stack_q [STACK_DEPTH];
    logic [DW-1:0]  depth_q;
    logic [DW-1:0]  depth_d;
    logic           push;
    logic           is_empty;
    logic           is_full;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  push_idx;

    // Return address and sequential successor share the same wrapped increment.
    assign pc_inc   = pc_q + D'(1);
    // Offset is sign-extended to PC width so the add wraps modulo 2^D.
    assign off_ext  = {{(D - OFF_W){offset[OFF_W-1]}}, offset};
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(STACK_DEPTH));
    assign top_idx  = IW'(depth_q - DW'(1));
    assign push_idx = IW'(depth_q);

    assign prog_ctr    = pc_q;
    assign depth       = depth_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    // Stale entries above depth are masked so an empty stack always reads zero.
    assign ret_top     = is_empty ? '0 : stack_q[top_idx];
    assign fault       = (state_q == FAULT);

    // Next-state decode: FAULT and stall both leave everything as-is.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (state_q == RUN && !stall) begin
            case (op)
                OP_BR_REL: pc_d = cond ? (pc_q + off_ext) : pc_inc;
                OP_BR_ABS: pc_d = cond ? target : pc_inc;
                OP_JMP:    pc_d = target;
                OP_CALL: begin
                    if (is_full) begin
                        state_d = FAULT;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        pc_d    = target;
                    end
                end
                OP_RET: begin
                    if (is_empty) begin
                        state_d = FAULT;
                    end else begin
                        depth_d = depth_q - DW'(1);
                        pc_d    = stack_q[top_idx];
                    end
                end
                default:   pc_d = pc_inc;
            endcase
        end
    end

    // State, PC, depth and stack registers; synchronous reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= D'(RESET_PC);
            depth_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            if (push) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end

endmodule
